fmul_pipe: RTL and testbench

Parametrised, pipelined IEEE 754 binary floating-point multiplier with valid/ready handshakes on input and output. It generalises the combinational single-precision multiplier to any exponent/mantissa width, and adds round-to-nearest-even, signed zeros and exception flags. It sits between operand-issue logic and a result consumer that may stall. One multiply can be accepted per clock.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_round_rne.sv | 35 +++
 rtl/fmul_pipe.sv | 176 +++++++++++++++++
 tb/tb_fmul_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE 754 helpers for the pipelined floating-point datapath blocks.
// Default geometry is binary32; modules derive their own widths from EXP_W/MAN_W.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int W         = 1 + EXP_W_DEF + MAN_W_DEF;
  localparam int BIAS      = (1 << (EXP_W_DEF - 1)) - 1;
  localparam int EXP_MAX   = (1 << EXP_W_DEF) - 1;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_NORM = 3'd1;
  localparam logic [2:0] CLS_INF  = 3'd2;
  localparam logic [2:0] CLS_QNAN = 3'd3;
  localparam logic [2:0] CLS_SNAN = 3'd4;

  // Special-case code carried down the pipe once both operands are classified
  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_ZERO = 2'd3;

  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_max_of(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand with guard/round/sticky,
// including renormalisation when the increment carries out of the top bit.
module fp_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]          sig,
  input  logic signed [EXP_W+1:0] exp_in,
  input  logic                    guard,
  input  logic                    rnd,
  input  logic                    sticky,
  output logic [MAN_W-1:0]        man,
  output logic signed [EXP_W+1:0] exp_out,
  output logic                    inexact
);

  localparam logic signed [EXP_W+1:0] ONE_S = (EXP_W + 2)'(1);

  logic             round_up;
  logic [MAN_W+1:0] sum;

  always_comb begin
    round_up = guard & (rnd | sticky | sig[0]);
    sum      = {1'b0, sig} + {{(MAN_W + 1){1'b0}}, round_up};
    inexact  = guard | rnd | sticky;
    if (sum[MAN_W+1]) begin
      man     = sum[MAN_W:1];
      exp_out = exp_in + ONE_S;
    end else begin
      man     = sum[MAN_W-1:0];
      exp_out = exp_in;
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage IEEE 754 multiplier (decode, multiply, normalise/round) with
// RNE rounding, DAZ/FTZ, exception flags and a globally stalled valid/ready pipe.
module fmul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [EXP_W+MAN_W:0]   out_o,
  output logic [3:0]             flags_o
);

  localparam int WW = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'(bias_of(EXP_W));
  localparam logic signed [EW-1:0] EMAX_S = EW'(exp_max_of(EXP_W));
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S = '0;
  localparam logic [63:0]          NAN_FULL = canon_nan(EXP_W, MAN_W);
  localparam logic [WW-1:0]        QNAN   = NAN_FULL[WW-1:0];

  function automatic logic [2:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    if (e == '0) return CLS_ZERO;
    if (e != '1) return CLS_NORM;
    if (m == '0) return CLS_INF;
    return m[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
  endfunction

  function automatic logic [WW+3:0] pack_norm(input logic s, input logic signed [EW-1:0] e,
                                              input logic [MAN_W-1:0] m, input logic inx);
    logic [WW-1:0] w;
    logic [3:0]    f;
    f = '0;
    if (e >= EMAX_S) begin
      w = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f[FLG_OVERFLOW] = 1'b1;
      f[FLG_INEXACT]  = 1'b1;
    end else if (e <= ZERO_S) begin
      w = {s, {(WW - 1){1'b0}}};
      f[FLG_UNDERFLOW] = 1'b1;
      f[FLG_INEXACT]   = 1'b1;
    end else begin
      w = {s, e[EXP_W-1:0], m};
      f[FLG_INEXACT] = inx;
    end
    return {w, f};
  endfunction

  logic                 advance;
  logic                 vld_p0, vld_p1, vld_p2;
  logic [2:0]           cls_a, cls_b;
  logic                 is_nan, is_inf, is_zero, inv_d;
  logic [1:0]           spec_d;
  logic                 sign_p0, inv_p0;
  logic [1:0]           spec_p0;
  logic [EXP_W-1:0]     ea_p0, eb_p0;
  logic [SW-1:0]        ma_p0, mb_p0;
  logic                 sign_p1, inv_p1;
  logic [1:0]           spec_p1;
  logic signed [EW-1:0] exp_p1;
  logic [PW-1:0]        prod_p1;
  logic [PW-1:0]        shifted;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]     man_r;
  logic                 inex_r;
  logic [WW-1:0]        res_d;
  logic [3:0]           flg_d;

  assign advance     = !vld_p2 || out_ready_i;
  assign in_ready_o  = advance;
  assign out_valid_o = vld_p2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= in_valid_i;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1: decode, subnormals read as zero
  always_comb begin
    cls_a   = classify(a_i[WW-2:MAN_W], a_i[MAN_W-1:0]);
    cls_b   = classify(b_i[WW-2:MAN_W], b_i[MAN_W-1:0]);
    is_nan  = (cls_a == CLS_QNAN) || (cls_a == CLS_SNAN) || (cls_b == CLS_QNAN) || (cls_b == CLS_SNAN);
    is_inf  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
    is_zero = (cls_a == CLS_ZERO) || (cls_b == CLS_ZERO);
    inv_d   = (is_inf && is_zero) || (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
    spec_d  = SP_NONE;
    if (is_nan || (is_inf && is_zero)) spec_d = SP_NAN;
    else if (is_inf)                   spec_d = SP_INF;
    else if (is_zero)                  spec_d = SP_ZERO;
  end

  always_ff @(posedge clk_i) begin
    if (advance) begin
      sign_p0 <= a_i[WW-1] ^ b_i[WW-1];
      spec_p0 <= spec_d;
      inv_p0  <= inv_d;
      ea_p0   <= a_i[WW-2:MAN_W];
      eb_p0   <= b_i[WW-2:MAN_W];
      ma_p0   <= {1'b1, a_i[MAN_W-1:0]};
      mb_p0   <= {1'b1, b_i[MAN_W-1:0]};
    end
  end

  // Stage 2: significand product and signed biased exponent sum
  always_ff @(posedge clk_i) begin
    if (advance) begin
      sign_p1 <= sign_p0;
      spec_p1 <= spec_p0;
      inv_p1  <= inv_p0;
      prod_p1 <= {{SW{1'b0}}, ma_p0} * {{SW{1'b0}}, mb_p0};
      exp_p1  <= $signed({2'b00, ea_p0}) + $signed({2'b00, eb_p0}) - BIAS_S;
    end
  end

  // Stage 3: normalise, round, then range-check and special-case override
  always_comb begin
    shifted = prod_p1[PW-1] ? prod_p1 : {prod_p1[PW-2:0], 1'b0};
    exp_n   = exp_p1 + (prod_p1[PW-1] ? ONE_S : ZERO_S);
  end

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sig     (shifted[PW-1 -: SW]),
    .exp_in  (exp_n),
    .guard   (shifted[MAN_W]),
    .rnd     (shifted[MAN_W-1]),
    .sticky  (|shifted[MAN_W-2:0]),
    .man     (man_r),
    .exp_out (exp_r),
    .inexact (inex_r)
  );

  always_comb begin
    res_d = '0;
    flg_d = '0;
    case (spec_p1)
      SP_NAN: begin
        res_d = QNAN;
        flg_d[FLG_INVALID] = inv_p1;
      end
      SP_INF:  res_d = {sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: res_d = {sign_p1, {(WW - 1){1'b0}}};
      default: {res_d, flg_d} = pack_norm(sign_p1, exp_r, man_r, inex_r);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_o   <= '0;
      flags_o <= '0;
    end else if (advance && vld_p1) begin
      out_o   <= res_d;
      flags_o <= flg_d;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: scoreboard of expected {result, flags}
// filled as operands are accepted and drained as results are taken.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] a_i, b_i, out_o;
  logic [3:0]  flags_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_push = 0;
  int n_rx = 0;

  logic [35:0] sb_q[$];
  logic [35:0] mon_exp;
  logic [35:0] held;
  logic [99:0] dir_vec [0:11];

  fmul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_o       (out_o),
    .flags_o     (flags_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $error("FAIL sb_extra: observed %h_%b expected no result", out_o, flags_o);
      end else begin
        mon_exp = sb_q.pop_front();
        n_rx++;
        assert ({out_o, flags_o} === mon_exp) else begin
          n_bad++;
          $error("FAIL result: observed %h_%b expected %h_%b", out_o, flags_o, mon_exp[35:4], mon_exp[3:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [35:0] exp, input bit push);
    bit ok;
    ok = 1'b0;
    a_i = a;
    b_i = b;
    in_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: observed in_ready_o=0 expected 1 within 100 cycles");
    end else if (push) begin
      sb_q.push_back(exp);
      n_push++;
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < 50) begin
      @(posedge clk);
      i++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_latency(input string tag);
    @(negedge clk);
    chk({tag, "_c1"}, 64'(out_valid_o), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_c2"}, 64'(out_valid_o), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_c3"}, 64'(out_valid_o), 64'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    a_i         = '0;
    b_i         = '0;
    dir_vec = '{
      {32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
      {32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101},
      {32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011},
      {32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
      {32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000},
      {32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000},
      {32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001},
      {32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001},
      {32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000},
      {32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000},
      {32'h00400000, 32'h40000000, 32'h00000000, 4'b0000},
      {32'hC0000000, 32'hC0400000, 32'h40C00000, 4'b0000}
    };

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_o), 64'h0);
    chk("rst_out",       64'(out_o),       64'h0);
    chk("rst_flags",     64'(flags_o),     64'h0);
    chk("rst_in_ready",  64'(in_ready_o),  64'h1);
    @(posedge clk); #1;
    rst_i = 1'b0;

    send(32'h3FC00000, 32'h40000000, {32'h40400000, 4'b0000}, 1'b1);
    check_latency("lat_first");
    drain();

    for (int i = 0; i < 12; i++)
      send(dir_vec[i][99:68], dir_vec[i][67:36], dir_vec[i][35:0], 1'b1);
    drain();

    send(32'h3F800000, 32'h40000000, {32'h40000000, 4'b0000}, 1'b1);
    send(32'h40000000, 32'h40000000, {32'h40800000, 4'b0000}, 1'b1);
    send(32'h40400000, 32'h40000000, {32'h40C00000, 4'b0000}, 1'b1);
    out_ready_i = 1'b0;
    held = {out_o, flags_o};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  64'(in_ready_o),        64'h0);
      chk("stall_out_valid", 64'(out_valid_o),       64'h1);
      chk("stall_hold",      64'({out_o, flags_o}),  64'(held));
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    send(32'h3FC00000, 32'h3FC00000, {32'h40100000, 4'b0000}, 1'b1);
    send(32'h3F000000, 32'h40800000, {32'h40000000, 4'b0000}, 1'b1);
    send(32'hBF800000, 32'h40400000, {32'hC0400000, 4'b0000}, 1'b1);
    drain();
    chk("stream_count", 64'(n_rx), 64'(n_push));

    out_ready_i = 1'b0;
    send(32'h40000000, 32'h40000000, 36'h0, 1'b0);
    send(32'h40400000, 32'h40400000, 36'h0, 1'b0);
    send(32'h3F800000, 32'h3F800000, 36'h0, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("midrst_out_valid", 64'(out_valid_o), 64'h0);
    chk("midrst_out",       64'(out_o),       64'h0);
    chk("midrst_flags",     64'(flags_o),     64'h0);
    out_ready_i = 1'b1;
    send(32'h40000000, 32'h40400000, {32'h40C00000, 4'b0000}, 1'b1);
    check_latency("lat_after_rst");
    drain();

    chk("final_count", 64'(n_rx), 64'(n_push));
    chk("sb_empty",    64'(sb_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
